// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer for the FFT magnitude path.
// Gates ADC samples into the FFT core in FFT_LEN frames, writes the returned
// magnitude stream into a ping-pong spectrum RAM, tracks the peak bin over the
// positive-frequency half (DC excluded), and publishes completed banks to a
// consumer over a ready/ack handshake.
module fft_frame_ctrl #(
    parameter int FFT_LEN = 1024,
    parameter int ADDR_W  = 10,
    parameter int SMP_W   = 16,
    parameter int MAG_W   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [SMP_W-1:0]  smp_data,
    input  logic              smp_valid,
    output logic [SMP_W-1:0]  fft_s_data,
    output logic              fft_s_valid,
    output logic              fft_s_last,
    input  logic [MAG_W-1:0]  mag_data,
    input  logic              mag_valid,
    input  logic              mag_eop,
    output logic              buf_we,
    output logic [ADDR_W:0]   buf_addr,
    output logic [MAG_W-1:0]  buf_wdata,
    output logic              frame_ready,
    output logic              frame_bank,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [MAG_W-1:0]  peak_mag,
    input  logic              frame_ack,
    output logic              busy,
    output logic [15:0]       drop_cnt,
    output logic              err
);

    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_LEN - 1);
    localparam logic [ADDR_W-1:0] HALF_BIN = ADDR_W'(FFT_LEN / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT_MAG,
        S_COLLECT,
        S_PUBLISH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [ADDR_W-1:0] bin_q, bin_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              wb_q, wb_d;
    logic              stop_pend_q, stop_pend_d;
    logic [ADDR_W-1:0] pk_bin_q, pk_bin_d;
    logic [MAG_W-1:0]  pk_mag_q, pk_mag_d;
    logic [SMP_W-1:0]  fft_s_data_q, fft_s_data_d;
    logic              fft_s_valid_q, fft_s_valid_d;
    logic              fft_s_last_q, fft_s_last_d;
    logic              buf_we_q, buf_we_d;
    logic [ADDR_W:0]   buf_addr_q, buf_addr_d;
    logic [MAG_W-1:0]  buf_wdata_q, buf_wdata_d;
    logic              frame_ready_q, frame_ready_d;
    logic              frame_bank_q, frame_bank_d;
    logic [ADDR_W-1:0] peak_bin_q, peak_bin_d;
    logic [MAG_W-1:0]  peak_mag_q, peak_mag_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              err_q, err_d;
    logic              mag_wr;
    logic              drop;

    // Next-state, datapath strobes and bookkeeping for the frame sequencer
    always_comb begin
        state_d       = state_q;
        smp_cnt_d     = smp_cnt_q;
        bin_d         = bin_q;
        tmo_d         = tmo_q;
        wb_d          = wb_q;
        stop_pend_d   = stop_pend_q | stop;
        pk_bin_d      = pk_bin_q;
        pk_mag_d      = pk_mag_q;
        fft_s_data_d  = fft_s_data_q;
        fft_s_valid_d = 1'b0;
        fft_s_last_d  = 1'b0;
        buf_we_d      = 1'b0;
        buf_addr_d    = buf_addr_q;
        buf_wdata_d   = buf_wdata_q;
        frame_ready_d = frame_ready_q & ~frame_ack;
        frame_bank_d  = frame_bank_q;
        peak_bin_d    = peak_bin_q;
        peak_mag_d    = peak_mag_q;
        drop_cnt_d    = drop_cnt_q;
        err_d         = err_q;
        mag_wr        = 1'b0;
        drop          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FILL;
                    stop_pend_d = 1'b0;
                end
            end
            S_FILL: begin
                // smp_cnt wraps back to 0 on the last sample, so every FILL starts at 0
                if (smp_valid) begin
                    fft_s_data_d  = smp_data;
                    fft_s_valid_d = 1'b1;
                    fft_s_last_d  = (smp_cnt_q == LAST_BIN);
                    smp_cnt_d     = smp_cnt_q + ADDR_W'(1);
                    if (smp_cnt_q == LAST_BIN) begin
                        state_d  = S_WAIT_MAG;
                        tmo_d    = '0;
                        bin_d    = '0;
                        pk_bin_d = ADDR_W'(1);
                        pk_mag_d = '0;
                    end
                end
            end
            S_WAIT_MAG: begin
                if (mag_valid) begin
                    mag_wr = 1'b1;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    drop    = 1'b1;
                    state_d = S_FILL;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_COLLECT: begin
                if (mag_valid) begin
                    mag_wr = 1'b1;
                end
            end
            S_PUBLISH: begin
                // An ack in this cycle frees the other bank, so the new frame can take it
                if (!frame_ready_q || frame_ack) begin
                    frame_ready_d = 1'b1;
                    frame_bank_d  = wb_q;
                    peak_bin_d    = pk_bin_q;
                    peak_mag_d    = pk_mag_q;
                    wb_d          = ~wb_q;
                end else begin
                    drop = 1'b1;
                end
                if (stop_pend_q || stop) begin
                    state_d     = S_IDLE;
                    stop_pend_d = 1'b0;
                end else begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Magnitude write path shared by WAIT_MAG (bin 0) and COLLECT
        if (mag_wr) begin
            buf_we_d    = 1'b1;
            buf_addr_d  = {wb_q, bin_q};
            buf_wdata_d = mag_data;
            bin_d       = bin_q + ADDR_W'(1);
            if (bin_q != '0 && bin_q < HALF_BIN && mag_data > pk_mag_q) begin
                pk_bin_d = bin_q;
                pk_mag_d = mag_data;
            end
            if (bin_q == LAST_BIN) begin
                state_d = S_PUBLISH;
            end else if (mag_eop) begin
                err_d   = 1'b1;
                drop    = 1'b1;
                state_d = S_FILL;
            end else begin
                state_d = S_COLLECT;
            end
        end

        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            smp_cnt_q     <= '0;
            bin_q         <= '0;
            tmo_q         <= '0;
            wb_q          <= 1'b0;
            stop_pend_q   <= 1'b0;
            pk_bin_q      <= '0;
            pk_mag_q      <= '0;
            fft_s_data_q  <= '0;
            fft_s_valid_q <= 1'b0;
            fft_s_last_q  <= 1'b0;
            buf_we_q      <= 1'b0;
            buf_addr_q    <= '0;
            buf_wdata_q   <= '0;
            frame_ready_q <= 1'b0;
            frame_bank_q  <= 1'b0;
            peak_bin_q    <= '0;
            peak_mag_q    <= '0;
            drop_cnt_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            smp_cnt_q     <= smp_cnt_d;
            bin_q         <= bin_d;
            tmo_q         <= tmo_d;
            wb_q          <= wb_d;
            stop_pend_q   <= stop_pend_d;
            pk_bin_q      <= pk_bin_d;
            pk_mag_q      <= pk_mag_d;
            fft_s_data_q  <= fft_s_data_d;
            fft_s_valid_q <= fft_s_valid_d;
            fft_s_last_q  <= fft_s_last_d;
            buf_we_q      <= buf_we_d;
            buf_addr_q    <= buf_addr_d;
            buf_wdata_q   <= buf_wdata_d;
            frame_ready_q <= frame_ready_d;
            frame_bank_q  <= frame_bank_d;
            peak_bin_q    <= peak_bin_d;
            peak_mag_q    <= peak_mag_d;
            drop_cnt_q    <= drop_cnt_d;
            err_q         <= err_d;
        end
    end

    assign fft_s_data  = fft_s_data_q;
    assign fft_s_valid = fft_s_valid_q;
    assign fft_s_last  = fft_s_last_q;
    assign buf_we      = buf_we_q;
    assign buf_addr    = buf_addr_q;
    assign buf_wdata   = buf_wdata_q;
    assign frame_ready = frame_ready_q;
    assign frame_bank  = frame_bank_q;
    assign peak_bin    = peak_bin_q;
    assign peak_mag    = peak_mag_q;
    assign busy        = (state_q != S_IDLE);
    assign drop_cnt    = drop_cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: scoreboard bench for fft_frame_ctrl.
// Forwarded samples and spectrum writes are pushed to queues when driven and
// popped by a negedge monitor; frame publication results are checked against
// hand-derived constants for each scenario.
module tb_fft_frame_ctrl;
    localparam int FFT_LEN = 1024;
    localparam int ADDR_W  = 10;
    localparam int SMP_W   = 16;
    localparam int MAG_W   = 32;
    localparam int TIMEOUT = 4096;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [SMP_W-1:0]  smp_data = '0;
    logic              smp_valid = 1'b0;
    logic [SMP_W-1:0]  fft_s_data;
    logic              fft_s_valid;
    logic              fft_s_last;
    logic [MAG_W-1:0]  mag_data = '0;
    logic              mag_valid = 1'b0;
    logic              mag_eop = 1'b0;
    logic              buf_we;
    logic [ADDR_W:0]   buf_addr;
    logic [MAG_W-1:0]  buf_wdata;
    logic              frame_ready;
    logic              frame_bank;
    logic [ADDR_W-1:0] peak_bin;
    logic [MAG_W-1:0]  peak_mag;
    logic              frame_ack = 1'b0;
    logic              busy;
    logic [15:0]       drop_cnt;
    logic              err;

    fft_frame_ctrl #(
        .FFT_LEN(FFT_LEN), .ADDR_W(ADDR_W), .SMP_W(SMP_W), .MAG_W(MAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .smp_data(smp_data), .smp_valid(smp_valid),
        .fft_s_data(fft_s_data), .fft_s_valid(fft_s_valid), .fft_s_last(fft_s_last),
        .mag_data(mag_data), .mag_valid(mag_valid), .mag_eop(mag_eop),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .frame_ready(frame_ready), .frame_bank(frame_bank),
        .peak_bin(peak_bin), .peak_mag(peak_mag), .frame_ack(frame_ack),
        .busy(busy), .drop_cnt(drop_cnt), .err(err)
    );

    always #5 clk = ~clk;

    logic [16:0]      fq[$];
    logic [42:0]      wq[$];
    logic [16:0]      fe;
    logic [42:0]      we;
    logic [MAG_W-1:0] mags [FFT_LEN];
    int               n_chk = 0;
    int               n_pass = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (fft_s_valid) begin
            if (fq.size() == 0) begin
                chk_eq("fft_extra_valid", fft_s_valid, 0);
            end else begin
                fe = fq.pop_front();
                chk_eq("fft_data", fft_s_data, fe[15:0]);
                chk_eq("fft_last", fft_s_last, fe[16]);
            end
        end
        if (buf_we) begin
            if (wq.size() == 0) begin
                chk_eq("buf_extra_we", buf_we, 0);
            end else begin
                we = wq.pop_front();
                chk_eq("buf_addr", buf_addr, we[42:32]);
                chk_eq("buf_wdata", buf_wdata, we[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mags(input logic [MAG_W-1:0] base);
        for (int b = 0; b < FFT_LEN; b++) mags[b] = base;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_samples(input int stop_at);
        for (int i = 0; i < FFT_LEN; i++) begin
            smp_data  = SMP_W'($urandom);
            smp_valid = 1'b1;
            stop      = (i == stop_at);
            fq.push_back({(i == FFT_LEN - 1), smp_data});
            tick();
        end
        smp_valid = 1'b0;
        stop      = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_mags(input logic bank, input int n_bins, input int eop_bin, input bit ack_pub);
        for (int b = 0; b < n_bins; b++) begin
            mag_data  = mags[b];
            mag_valid = 1'b1;
            mag_eop   = (b == FFT_LEN - 1) || (b == eop_bin);
            wq.push_back({bank, ADDR_W'(b), mags[b]});
            tick();
            if (b == eop_bin) break;
        end
        mag_valid = 1'b0;
        mag_eop   = 1'b0;
        if (ack_pub) begin
            frame_ack = 1'b1;
            tick();
            frame_ack = 1'b0;
            chk_eq("ack_at_publish_ready", frame_ready, 1);
        end
    endtask

    task automatic check_frame(input logic er, input logic eb, input int epb,
                               input logic [MAG_W-1:0] epm, input int ed);
        repeat (2) tick();
        chk_eq("frame_ready", frame_ready, er);
        chk_eq("frame_bank", frame_bank, eb);
        chk_eq("peak_bin", peak_bin, epb);
        chk_eq("peak_mag", peak_mag, epm);
        chk_eq("drop_cnt", drop_cnt, ed);
        chk_eq("wr_queue_drained", wq.size(), 0);
        chk_eq("smp_queue_drained", fq.size(), 0);
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk_eq("ack_clears_ready", frame_ready, 0);
    endtask

    task automatic idle_discard();
        smp_valid = 1'b1;
        repeat (5) tick();
        smp_valid = 1'b0;
        tick();
        chk_eq("idle_no_forward", fft_s_valid, 0);
    endtask

    task automatic check_all_zero();
        chk_eq("rst_fft_data", fft_s_data, 0);
        chk_eq("rst_fft_valid", fft_s_valid, 0);
        chk_eq("rst_fft_last", fft_s_last, 0);
        chk_eq("rst_buf_we", buf_we, 0);
        chk_eq("rst_buf_addr", buf_addr, 0);
        chk_eq("rst_buf_wdata", buf_wdata, 0);
        chk_eq("rst_frame_ready", frame_ready, 0);
        chk_eq("rst_frame_bank", frame_bank, 0);
        chk_eq("rst_peak_bin", peak_bin, 0);
        chk_eq("rst_peak_mag", peak_mag, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_drop_cnt", drop_cnt, 0);
        chk_eq("rst_err", err, 0);
    endtask

    initial begin
        repeat (3) tick();
        check_all_zero();
        rst_n = 1'b1;
        tick();
        idle_discard();
        chk_eq("idle_busy", busy, 0);

        // Single peak, published to bank 0
        set_mags(32'h10);
        mags[37] = 32'h5000;
        start_pulse();
        chk_eq("busy_after_start", busy, 1);
        send_samples(-1);
        send_mags(1'b0, FFT_LEN, -1, 1'b0);
        chk_eq("last_bin_we", buf_we, 1);
        chk_eq("last_bin_addr", buf_addr, 11'h3FF);
        chk_eq("ready_not_before_publish", frame_ready, 0);
        tick();
        chk_eq("ready_after_publish", frame_ready, 1);
        check_frame(1'b1, 1'b0, 37, 32'h5000, 0);
        ack();

        // Tie keeps lowest bin; DC and mirror half excluded
        set_mags(32'h10);
        mags[0] = 32'hFFFF; mags[37] = 32'h5000; mags[90] = 32'h5000; mags[600] = 32'hFFFF;
        send_samples(-1);
        send_mags(1'b1, FFT_LEN, -1, 1'b0);
        check_frame(1'b1, 1'b1, 37, 32'h5000, 0);
        ack();

        // No ack across three frames: first published, next two dropped into bank 1
        set_mags(32'h20);
        mags[5] = 32'h1234; mags[511] = 32'h1000;
        send_samples(-1);
        send_mags(1'b0, FFT_LEN, -1, 1'b0);
        check_frame(1'b1, 1'b0, 5, 32'h1234, 0);
        set_mags(32'h20);
        mags[200] = 32'h9999;
        send_samples(-1);
        send_mags(1'b1, FFT_LEN, -1, 1'b0);
        check_frame(1'b1, 1'b0, 5, 32'h1234, 1);
        set_mags(32'h20);
        mags[300] = 32'h8888;
        send_samples(-1);
        send_mags(1'b1, FFT_LEN, -1, 1'b0);
        check_frame(1'b1, 1'b0, 5, 32'h1234, 2);
        ack();
        for (int b = 0; b < FFT_LEN; b++) mags[b] = MAG_W'(b);
        send_samples(-1);
        send_mags(1'b1, FFT_LEN, -1, 1'b0);
        check_frame(1'b1, 1'b1, 511, 32'd511, 2);

        // Ack coincides with PUBLISH: no drop, new bank published, all-zero peak default
        set_mags(32'h0);
        send_samples(-1);
        send_mags(1'b0, FFT_LEN, -1, 1'b1);
        check_frame(1'b1, 1'b0, 1, 32'h0, 2);

        // Early end-of-packet on bin 500
        set_mags(32'h10);
        mags[37] = 32'h5000;
        chk_eq("err_before_eop", err, 0);
        send_samples(-1);
        send_mags(1'b1, FFT_LEN, 500, 1'b0);
        check_frame(1'b1, 1'b0, 1, 32'h0, 3);
        chk_eq("eop_err", err, 1);
        chk_eq("eop_back_to_fill", busy, 1);

        // Stop mid-FILL: frame completes, publishes, then IDLE
        ack();
        set_mags(32'h7);
        send_samples(512);
        send_mags(1'b1, FFT_LEN, -1, 1'b0);
        check_frame(1'b1, 1'b1, 1, 32'h7, 3);
        chk_eq("stop_idle_busy", busy, 0);
        chk_eq("err_sticky", err, 1);
        idle_discard();

        // Reset in the middle of COLLECT
        start_pulse();
        send_samples(-1);
        set_mags(32'h10);
        send_mags(1'b0, 300, -1, 1'b0);
        rst_n = 1'b0;
        tick();
        check_all_zero();
        rst_n = 1'b1;
        tick();
        chk_eq("post_reset_busy", busy, 0);
        chk_eq("post_reset_wr_queue", wq.size(), 0);

        // WAIT_MAG timeout with no magnitude stream
        start_pulse();
        send_samples(-1);
        repeat (3990) tick();
        chk_eq("err_before_timeout", err, 0);
        repeat (110) tick();
        chk_eq("err_after_timeout", err, 1);
        chk_eq("timeout_no_publish", frame_ready, 0);
        chk_eq("timeout_busy", busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame-level sequencer for the FFT magnitude path. It gates ADC samples into the FFT core in fixed-length frames, then collects the squared-sum/CORDIC magnitude stream bin by bin into a ping-pong spectrum RAM. For each frame it tracks the peak bin and publishes completed banks to a downstream consumer over a ready/ack handshake. It sits between the ADC capture front end, the FFT core's input port, the magnitude datapath's output, and the spectrum consumer.

## Interface
- FFT_LEN, 1024: samples per frame and bins per spectrum; power of two.
- ADDR_W, 10: log2(FFT_LEN).
- SMP_W, 16: sample width.
- MAG_W, 32: magnitude width.
- TIMEOUT, 4096: maximum cycles in WAIT_MAG without mag_valid.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  pulse; begin acquisition (ignored unless IDLE)
- stop  in  1  pulse; stop at the next frame boundary
- smp_data  in  SMP_W  ADC sample
- smp_valid  in  1  sample strobe
- fft_s_data  out  SMP_W  sample to FFT core
- fft_s_valid  out  1  sample valid to FFT core
- fft_s_last  out  1  last sample of frame
- mag_data  in  MAG_W  magnitude from modulus datapath
- mag_valid  in  1  magnitude valid
- mag_eop  in  1  magnitude end of frame
- buf_we  out  1  spectrum RAM write enable
- buf_addr  out  ADDR_W+1  {bank, bin}
- buf_wdata  out  MAG_W  magnitude written
- frame_ready  out  1  published bank available
- frame_bank  out  1  bank index of published frame
- peak_bin  out  ADDR_W  peak bin of published frame
- peak_mag  out  MAG_W  peak magnitude of published frame
- frame_ack  in  1  consumer releases published bank
- busy  out  1  state != IDLE
- drop_cnt  out  16  frames discarded (saturating)
- err  out  1  sticky; bin-count mismatch or timeout

## Operation
- States and transitions:
  - IDLE → FILL on start.
  - FILL: forward smp_valid samples; count 0..FFT_LEN-1; → WAIT_MAG after the sample with count FFT_LEN-1.
  - WAIT_MAG: → COLLECT on the first mag_valid, which is consumed as bin 0. → FILL on timeout, with err set and the frame dropped.
  - COLLECT: each mag_valid writes the bin. Ends on mag_valid with bin == FFT_LEN-1. → PUBLISH.
  - PUBLISH: one cycle. → FILL, or → IDLE if stop is pending.
- Samples arriving outside FILL are discarded and do not count as drops.
- Write bank wb starts at 0. On PUBLISH:
  - If frame_ready==0, or frame_ack is high this cycle: publish wb, latch the peak into the outputs, set frame_ready and frame_bank=wb, then toggle wb.
  - Otherwise (consumer still holds the other bank): drop the frame, drop_cnt+1, wb unchanged.
- frame_ack while frame_ready clears frame_ready next cycle. frame_ack while frame_ready==0 is ignored.
- Bin checks:
  - mag_eop on a bin < FFT_LEN-1 sets err; the frame is dropped and the state goes → FILL.
  - mag_eop absent on bin FFT_LEN-1 is not an error.
- Peak search covers bins 1..FFT_LEN/2-1 only; DC and the mirror half are excluded. It updates only on a strictly greater value, so ties keep the lowest bin. Peak registers reset at the start of each frame to bin 1 with value 0.
- stop is latched as pending and cleared on entry to IDLE. start in IDLE clears pending stop.
- err clears only on reset.

## Timing
- fft_s_data/fft_s_valid/fft_s_last are registered: one cycle after smp_valid.
- buf_we/buf_addr/buf_wdata are registered: one cycle after mag_valid.
- Peak registers update in the same cycle as the corresponding write.
- frame_ready rises the cycle after PUBLISH. It rises no earlier than the last bin's buf_we.
- Reset values: all outputs 0; state IDLE; wb=0; pending stop 0.
- Reset mid-frame abandons everything. No partial publish occurs.
- Timeout counter restarts on entry to WAIT_MAG and counts every cycle.

## Test plan
- start, 1024 continuous samples, magnitude stream 1024 bins with bin 37 = 0x5000 (others 0x10) → fft_s_last on the 1024th sample; 1024 writes to bank 0; frame_ready=1, frame_bank=0, peak_bin=37, peak_mag=0x5000.
- Bins 37 and 90 both 0x5000, bin 0 = 0xFFFF, bin 600 = 0xFFFF → peak_bin=37.
- No ack across three frames → bank 0 published; frames 2 and 3 dropped, drop_cnt=2, writes to bank 1 only; ack → next frame published as bank 1.
- frame_ack in the same cycle as PUBLISH → no drop; the new bank is published and frame_ready stays 1.
- mag_eop on bin 500 → err=1, drop_cnt+1, state returns to FILL; with no magnitude after FILL → err after 4096 cycles.
- stop mid-FILL → current frame completes and publishes, then IDLE with busy=0. rst_n low mid-COLLECT → all outputs 0 next cycle.
